intt_seq: RTL and testbench
===========================

Name: intt_seq

Overview:
- Inverse number-theoretic transform engine for N=16, 8-bit coefficients. It is the decode side of the existing combinational forward NTT.
- Computes out[i] = n_inv * sum_j x[j]*w_inv^(i*j) mod q.
- Sequential: coefficients stream in serially, are buffered, processed by one shared modular MAC, and stream out in natural order with valid/ready backpressure.
- Sits after the forward NTT / pointwise-multiply stage to return polynomials to coefficient form.

Parameters:
- N, 16, transform length; fixed at 16 (4-bit indices, 272-cycle compute).
- DW, 8, coefficient, modulus and twiddle width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- q  input  DW  modulus; sampled with coefficient 0.
- w_inv  input  DW  inverse of the primitive N-th root mod q; sampled with coefficient 0.
- n_inv  input  DW  inverse of N mod q; sampled with coefficient 0.
- in_data  input  DW  input coefficient; values may be >= q.
- in_valid  input  1  in_data valid.
- in_ready  output  1  engine can accept a coefficient.
- out_data  output  DW  result coefficient, always < q.
- out_idx  output  4  index i of out_data.
- out_last  output  1  high with out_idx==15.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- busy  output  1  high in COMPUTE and DRAIN.

Behaviour:
- Reset state (rst_n low at posedge): state=LOAD, counters 0, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. Coefficient and result buffers are not cleared.
- Reset mid-operation: abandons the current block and discards partial results. The first beat after release is treated as coefficient 0.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid&in_ready; it is stored at x[cnt] and cnt increments.
  - On beat 0, q, w_inv and n_inv are latched. Later changes on those ports are ignored until the next block.
  - After beat 15 is accepted, go to COMPUTE the next cycle, with in_ready=0.
  - in_valid while in_ready=0 is ignored; no beat is lost or duplicated.
- COMPUTE:
  - Rows i=0..15, each taking 17 cycles.
  - Cycles j=0..15: acc <= (acc + x[j]*tw) mod q, with tw <= tw*s mod q.
  - Cycle 16 (SCALE): r[i] <= acc*n_inv mod q; acc <= 0; tw <= 1; s <= s*w_inv mod q.
  - Row-0 initial values: s=1, tw=1, acc=0.
  - Total 272 cycles; out_valid rises exactly 273 cycles after the last input beat was accepted.
- Arithmetic widths:
  - Products are 2*DW bits.
  - The acc+product sum is 2*DW+1 bits before reduction.
  - All stored values (acc, tw, s, r) are < q.
- DRAIN:
  - out_valid=1; out_data=r[k], out_idx=k, out_last=(k==15).
  - Outputs hold stable while out_ready=0.
  - k increments on out_valid&out_ready.
  - After k=15 is accepted, go to LOAD the next cycle: out_valid=0, in_ready=1, busy=0.
  - No overlap between blocks: next-block input is not accepted during DRAIN.
- Degenerate modulus: if latched q<2, COMPUTE still takes 272 cycles but every r[i]=0. No X/overflow from mod by 0.
- Twiddle validity (w_inv a true root, n_inv a true inverse) is the caller's responsibility. Results are then arithmetic as specified.

Optional Feature:
- Macro INTT_NSCALE_EN.
- Defined: the SCALE cycle multiplies by n_inv as above; output is the true inverse transform.
- Undefined: SCALE writes r[i] <= acc (unscaled sum mod q). The n_inv port is present but ignored. Cycle timing is identical (still 17 cycles/row).

Test Plan:
Common settings: q=17, w_inv=6 (w=3), n_inv=16, INTT_NSCALE_EN defined unless stated.
1. Impulse x=[1,0,...,0] -> all 16 outputs = 16. With the macro undefined, all outputs = 1.
2. Constant x all 1 -> out=[1,0,0,...,0]; out_last only on idx 15. First out_valid is 273 cycles after the last accept.
3. Round trip: x=[1,3,9,10,13,5,15,11,16,14,8,7,4,12,2,6] (forward NTT of a delta at index 1) -> out=[0,1,0,...,0].
4. Backpressure:
   - Hold out_ready=0 for 5 cycles at idx 6 -> out_data=r[6] and out_idx=6 stay stable; order and values are unchanged.
   - Toggle in_valid with gaps during LOAD -> identical results to the no-gap case.
5. Reset mid-COMPUTE (cycle 100): rst_n=0 for 1 cycle -> next cycle in_ready=1, out_valid=0, busy=0. A fresh impulse block then yields all 16s.
6. q=1 (or q=0) with x=[255,...] -> 16 outputs of 0. Changing q during LOAD after beat 0 has no effect on results.

Source files
------------

// File: rtl/intt_seq.sv
// Sequential 16-point inverse NTT: serial load, one shared modular MAC, serial drain.
// Macro INTT_NSCALE_EN: when defined, results are scaled by n_inv; otherwise unscaled sums mod q.
//
// state      | meaning
// ST_LOAD    | accepting 16 input coefficients; q/w_inv/n_inv latched on beat 0
// ST_COMPUTE | 16 rows x 17 cycles (16 MAC cycles + 1 SCALE cycle)
// ST_DRAIN   | presenting r[0..15] with valid/ready handshake
module intt_seq #(
   parameter int N  = 16,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] q,
   input  logic [DW-1:0] w_inv,
   input  logic [DW-1:0] n_inv,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic [3:0]    out_idx,
   output logic          out_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);
   typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_DRAIN} state_t;

   localparam logic [3:0] LAST      = 4'(N-1);
   localparam logic [4:0] SCALE_COL = 5'(N);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d, row_q, row_d, k_nxt;
   logic [4:0]    col_q, col_d;
   logic [DW-1:0] q_q, q_d, w_inv_q, w_inv_d;
   logic [DW-1:0] acc_q, acc_d, tw_q, tw_d, s_q, s_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [3:0]    out_idx_q, out_idx_d;
   logic          out_last_q, out_last_d, out_valid_q, out_valid_d;
   logic [DW-1:0] x_q [N];
   logic [DW-1:0] r_q [N];
   logic          x_we, r_we, cfg_we, is_scale;
   logic [DW-1:0] r_wdata, scale_k, red_a, red_b;
   logic [2*DW-1:0] mac_prod, tw_prod, scale_prod, s_prod;
   logic [2*DW:0]   mac_sum, red_a_in, red_b_in;

   // A modulus below 2 forces every residue to 0 and avoids a divide by zero.
   function automatic logic [DW-1:0] mod_red(input logic [2*DW:0] a, input logic [DW-1:0] m);
      if (m < DW'(2))
         return '0;
      return DW'(a % {{(DW+1){1'b0}}, m});
   endfunction

`ifdef INTT_NSCALE_EN
   logic [DW-1:0] n_inv_q, n_inv_d;
   assign n_inv_d = cfg_we ? n_inv : n_inv_q;
   assign scale_k = n_inv_q;
   always_ff @(posedge clk) begin
      if (!rst_n) n_inv_q <= '0;
      else        n_inv_q <= n_inv_d;
   end
`else
   // Scaling by 1 keeps the SCALE cycle and its reduction identical in both builds.
   logic unused_n_inv;
   assign unused_n_inv = ^n_inv;
   assign scale_k      = DW'(1);
`endif

   always_comb begin
      is_scale   = (col_q == SCALE_COL);
      mac_prod   = {{DW{1'b0}}, x_q[col_q[3:0]]} * {{DW{1'b0}}, tw_q};
      mac_sum    = {1'b0, mac_prod} + {{(DW+1){1'b0}}, acc_q};
      tw_prod    = {{DW{1'b0}}, tw_q} * {{DW{1'b0}}, s_q};
      scale_prod = {{DW{1'b0}}, acc_q} * {{DW{1'b0}}, scale_k};
      s_prod     = {{DW{1'b0}}, s_q} * {{DW{1'b0}}, w_inv_q};
      red_a_in   = is_scale ? {1'b0, scale_prod} : mac_sum;
      red_b_in   = is_scale ? {1'b0, s_prod} : {1'b0, tw_prod};
      red_a      = mod_red(red_a_in, q_q);
      red_b      = mod_red(red_b_in, q_q);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      col_d       = col_q;
      q_d         = q_q;
      w_inv_d     = w_inv_q;
      acc_d       = acc_q;
      tw_d        = tw_q;
      s_d         = s_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      x_we        = 1'b0;
      r_we        = 1'b0;
      cfg_we      = 1'b0;
      r_wdata     = red_a;
      k_nxt       = cnt_q + 4'd1;
      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               x_we  = 1'b1;
               cnt_d = k_nxt;
               if (cnt_q == 4'd0) begin
                  cfg_we  = 1'b1;
                  q_d     = q;
                  w_inv_d = w_inv;
               end
               if (cnt_q == LAST) begin
                  state_d = ST_COMPUTE;
                  cnt_d   = '0;
                  row_d   = '0;
                  col_d   = '0;
                  acc_d   = '0;
                  tw_d    = DW'(1);
                  s_d     = DW'(1);
               end
            end
         end
         ST_COMPUTE: begin
            if (!is_scale) begin
               acc_d = red_a;
               tw_d  = red_b;
               col_d = col_q + 5'd1;
            end else begin
               r_we  = 1'b1;
               acc_d = '0;
               tw_d  = DW'(1);
               s_d   = red_b;
               col_d = '0;
               row_d = row_q + 4'd1;
               if (row_q == LAST) begin
                  state_d = ST_DRAIN;
                  cnt_d   = '0;
               end
            end
         end
         ST_DRAIN: begin
            // First drain cycle loads r[0]; afterwards each handshake loads the next result.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = r_q[cnt_q];
               out_idx_d   = cnt_q;
               out_last_d  = (cnt_q == LAST);
            end else if (out_ready) begin
               if (cnt_q == LAST) begin
                  state_d     = ST_LOAD;
                  cnt_d       = '0;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else begin
                  cnt_d      = k_nxt;
                  out_data_d = r_q[k_nxt];
                  out_idx_d  = k_nxt;
                  out_last_d = (k_nxt == LAST);
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         cnt_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         q_q         <= '0;
         w_inv_q     <= '0;
         acc_q       <= '0;
         tw_q        <= '0;
         s_q         <= '0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         col_q       <= col_d;
         q_q         <= q_d;
         w_inv_q     <= w_inv_d;
         acc_q       <= acc_d;
         tw_q        <= tw_d;
         s_q         <= s_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (x_we) x_q[cnt_q] <= in_data;
      if (r_we) r_q[row_q] <= r_wdata;
   end

   assign in_ready  = (state_q == ST_LOAD);
   assign busy      = (state_q != ST_LOAD);
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_intt_seq.sv
// Directed bench for intt_seq: q=17, w_inv=6, n_inv=16 with hand-computed results.
module tb_intt_seq;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] q_i, w_inv_i, n_inv_i, in_data;
   logic       in_valid, in_ready;
   logic [7:0] out_data;
   logic [3:0] out_idx;
   logic       out_last, out_valid, out_ready, busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cyc = 0;

   logic [7:0] x_imp [16];
   logic [7:0] x_one [16];
   logic [7:0] x_rt  [16];
   logic [7:0] x_ff  [16];
   logic [7:0] e_imp [16];
   logic [7:0] e_one [16];
   logic [7:0] e_rt  [16];
   logic [7:0] e_zero[16];

   intt_seq dut (
      .clk(clk), .rst_n(rst_n), .q(q_i), .w_inv(w_inv_i), .n_inv(n_inv_i),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Later beats drive different config values that must be ignored.
   task automatic send_block(input logic [7:0] xs [16], input logic [7:0] qv,
                             input logic [7:0] q_late, input bit gap, input bit junk);
      for (int k = 0; k < 16; k++) begin
         if (gap && (k % 3 == 1)) begin
            in_valid = 1'b0;
            in_data  = 8'hA5;
            tick();
            tick();
         end
         in_valid = 1'b1;
         in_data  = xs[k];
         q_i      = (k == 0) ? qv : q_late;
         w_inv_i  = (k == 0) ? 8'd6 : 8'd2;
         n_inv_i  = (k == 0) ? 8'd16 : 8'd3;
         for (int w = 0; w < 50 && in_ready !== 1'b1; w++) tick();
         tick();
      end
      acc_cyc = cyc;
      in_valid = 1'b0;
      if (junk) begin
         in_valid = 1'b1;
         in_data  = 8'd99;
         repeat (30) tick();
         in_valid = 1'b0;
      end
   endtask

   task automatic recv_block(input logic [7:0] ex [16], input int stall_at, input bit check_lat);
      int w;
      w = 0;
      out_ready = 1'b1;
      while (out_valid !== 1'b1 && w < 600) begin
         tick();
         w++;
      end
      if (out_valid !== 1'b1) begin
         chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
         return;
      end
      if (check_lat) chk("latency", cyc - acc_cyc, 32'd273);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("out_idx[%0d]", k), {28'd0, out_idx}, k);
         chk($sformatf("out_last[%0d]", k), {31'd0, out_last}, (k == 15) ? 32'd1 : 32'd0);
         chk($sformatf("out_data[%0d]", k), {24'd0, out_data}, {24'd0, ex[k]});
         if (k == stall_at) begin
            out_ready = 1'b0;
            repeat (5) begin
               tick();
               chk("stall_valid", {31'd0, out_valid}, 32'd1);
               chk("stall_idx", {28'd0, out_idx}, k);
               chk("stall_data", {24'd0, out_data}, {24'd0, ex[k]});
            end
            out_ready = 1'b1;
         end
         tick();
      end
      chk("post_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_out_valid", {31'd0, out_valid}, 32'd0);
      chk("post_busy", {31'd0, busy}, 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 16; k++) begin
         x_imp[k]  = (k == 0) ? 8'd1 : 8'd0;
         x_one[k]  = 8'd1;
         x_ff[k]   = 8'd255;
         e_zero[k] = 8'd0;
         e_one[k]  = 8'd0;
         e_rt[k]   = 8'd0;
`ifdef INTT_NSCALE_EN
         e_imp[k]  = 8'd16;
`else
         e_imp[k]  = 8'd1;
`endif
      end
`ifdef INTT_NSCALE_EN
      e_one[0] = 8'd1;
      e_rt[1]  = 8'd1;
`else
      e_one[0] = 8'd16;
      e_rt[1]  = 8'd16;
`endif
      // 3^j mod 17: forward transform of a delta at index 1
      x_rt = '{8'd1, 8'd3, 8'd9, 8'd10, 8'd13, 8'd5, 8'd15, 8'd11,
               8'd16, 8'd14, 8'd8, 8'd7, 8'd4, 8'd12, 8'd2, 8'd6};

      rst_n = 1'b0; q_i = 8'd17; w_inv_i = 8'd6; n_inv_i = 8'd16;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      rst_n = 1'b1;
      tick();

      send_block(x_imp, 8'd17, 8'd17, 1'b0, 1'b0);
      recv_block(e_imp, -1, 1'b0);

      send_block(x_one, 8'd17, 8'd17, 1'b0, 1'b0);
      recv_block(e_one, -1, 1'b1);

      send_block(x_rt, 8'd17, 8'd17, 1'b0, 1'b0);
      repeat (10) tick();
      chk("compute_busy", {31'd0, busy}, 32'd1);
      chk("compute_in_ready", {31'd0, in_ready}, 32'd0);
      chk("compute_out_valid", {31'd0, out_valid}, 32'd0);
      recv_block(e_rt, -1, 1'b0);

      send_block(x_rt, 8'd17, 8'd17, 1'b0, 1'b0);
      recv_block(e_rt, 6, 1'b0);

      send_block(x_rt, 8'd17, 8'd17, 1'b1, 1'b1);
      recv_block(e_rt, -1, 1'b1);

      send_block(x_one, 8'd17, 8'd17, 1'b0, 1'b0);
      repeat (100) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      send_block(x_imp, 8'd17, 8'd17, 1'b0, 1'b0);
      recv_block(e_imp, -1, 1'b1);

      send_block(x_ff, 8'd1, 8'd13, 1'b0, 1'b0);
      recv_block(e_zero, -1, 1'b1);
      send_block(x_ff, 8'd0, 8'd13, 1'b0, 1'b0);
      recv_block(e_zero, -1, 1'b0);
      send_block(x_rt, 8'd17, 8'd5, 1'b0, 1'b0);
      recv_block(e_rt, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
